mem_issue_scheduler: RTL

- In-order allocation queue of memory micro-ops (loads/stores) placed between rename/dispatch and memory_pipeline.
- Holds each op until its store-data operand is ready, then issues it to memory_pipeline over a valid/ready handshake.
- Enforces memory ordering: stores issue in program order; loads never pass an older unissued store (relaxed by the optional feature).
- Wakes waiting store data from the common data bus (CDB).

---
 rtl/mem_sched_pkg.sv | 46 ++++
 rtl/mem_sched_age_select.sv | 34 +++
 rtl/mem_issue_scheduler.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_sched_pkg.sv
`default_nettype none
// mem_sched_pkg: field widths, queue entry layout and effective-address helper for mem_issue_scheduler.
// Rev 1.0. Option MEM_SCHED_LOAD_BYPASS_EN adds the per-entry ea field used for load bypass.
package mem_sched_pkg;

  localparam int OPC_W  = 4;
  localparam int TAG_W  = 5;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int OFF_W  = 8;
  localparam int IMM_W  = 4;
  localparam int DEST_W = 5;
  localparam int ARCH_W = 8;

  localparam int STORE_BIT   = 0;
  localparam int ZP_WRAP_BIT = 3;

  typedef struct packed {
    logic              valid;
    logic              issued;
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] base_val;
    logic [OFF_W-1:0]  offset;
    logic [IMM_W-1:0]  imm;
    logic [DEST_W-1:0] dest_reg;
    logic [ARCH_W-1:0] dest_arch_regs;
    logic [DATA_W-1:0] data;
    logic              data_rdy;
    logic [TAG_W-1:0]  data_tag;
`ifdef MEM_SCHED_LOAD_BYPASS_EN
    logic [ADDR_W-1:0] ea;
`endif
  } entry_t;

  // Zero-page mode wraps the low byte without carrying into the page byte.
  function automatic logic [ADDR_W-1:0] calc_ea(input logic [ADDR_W-1:0] base,
                                                input logic [OFF_W-1:0]  offset,
                                                input logic              zp_wrap);
    logic [7:0] lo;
    lo = base[7:0] + offset;
    if (zp_wrap) return {base[15:8], lo};
    return base + {8'b0, offset};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_sched_age_select.sv
`default_nettype none
// mem_sched_age_select: oldest eligible entry of a circular queue, scanning from head. Rev 1.0.
module mem_sched_age_select #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] eligible,
  input  logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] sel_idx,
  output logic             found
);

  logic [2*DEPTH-1:0] doubled;
  logic [DEPTH-1:0]   rotated;
  logic [PTR_W-1:0]   offs;

  assign doubled = {eligible, eligible};
  assign rotated = DEPTH'(doubled >> head);

  always_comb begin
    found = 1'b0;
    offs  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        found = 1'b1;
        offs  = PTR_W'(k);
      end
    end
  end

  assign sel_idx = head + offs;

endmodule
`default_nettype wire

// File: rtl/mem_issue_scheduler.sv
`default_nettype none
// mem_issue_scheduler: in-order memory op queue with CDB store-data wakeup and ordered issue. Rev 1.0.
// Option MEM_SCHED_LOAD_BYPASS_EN lets loads pass older unissued stores to a different ea.
module mem_issue_scheduler
  import mem_sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alloc_valid,
  output logic               alloc_ready,
  input  logic [OPC_W-1:0]   alloc_opcode,
  input  logic [ADDR_W-1:0]  alloc_base_val,
  input  logic [OFF_W-1:0]   alloc_offset,
  input  logic [IMM_W-1:0]   alloc_imm,
  input  logic [DEST_W-1:0]  alloc_dest_reg,
  input  logic [ARCH_W-1:0]  alloc_dest_arch_regs,
  input  logic [DATA_W-1:0]  alloc_data,
  input  logic [TAG_W-1:0]   alloc_data_tag,
  input  logic               alloc_data_rdy,
  input  logic               cdb_valid,
  input  logic [TAG_W-1:0]   cdb_tag,
  input  logic [DATA_W-1:0]  cdb_val,
  input  logic               flush,
  output logic               iss_valid,
  input  logic               iss_ready,
  output logic [OPC_W-1:0]   iss_opcode,
  output logic [ADDR_W-1:0]  iss_base_val,
  output logic [OFF_W-1:0]   iss_offset,
  output logic [DEST_W-1:0]  iss_dest_reg,
  output logic [DATA_W-1:0]  iss_data,
  output logic [IMM_W-1:0]   iss_imm,
  output logic [ARCH_W-1:0]  iss_dest_arch_regs,
  output logic [PTR_W:0]     occupancy
);

  entry_t           entries [DEPTH];
  entry_t           new_entry;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] age [DEPTH];
  logic [DEPTH-1:0] store_pend;
  logic [DEPTH-1:0] wake;
  logic [DEPTH-1:0] blocked;
  logic [DEPTH-1:0] eligible;
  logic [DEPTH-1:0] retire_mask;
  logic [PTR_W:0]   retire_cnt;
  logic [PTR_W-1:0] ret_idx;
  logic             ret_run;
  logic [PTR_W-1:0] sel_idx;
  logic             found;
  logic             alloc_fire;
  logic             issue_go;

  assign alloc_ready = (occupancy < (PTR_W+1)'(DEPTH)) && !flush;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign issue_go    = (!iss_valid || iss_ready) && found;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry_flags
    assign age[g]        = PTR_W'(g) - head;
    assign store_pend[g] = entries[g].valid && !entries[g].issued && entries[g].opcode[STORE_BIT];
    assign wake[g]       = entries[g].valid && !entries[g].data_rdy && cdb_valid &&
                           (entries[g].data_tag == cdb_tag);
  end

  always_comb begin
    new_entry                = '0;
    new_entry.valid          = 1'b1;
    new_entry.opcode         = alloc_opcode;
    new_entry.base_val       = alloc_base_val;
    new_entry.offset         = alloc_offset;
    new_entry.imm            = alloc_imm;
    new_entry.dest_reg       = alloc_dest_reg;
    new_entry.dest_arch_regs = alloc_dest_arch_regs;
    new_entry.data_tag       = alloc_data_tag;
    new_entry.data           = alloc_data;
    new_entry.data_rdy       = 1'b1;
    // A store still waiting on data can catch its producer on the CDB this very cycle.
    if (alloc_opcode[STORE_BIT] && !alloc_data_rdy) begin
      if (cdb_valid && cdb_tag == alloc_data_tag) new_entry.data = cdb_val;
      else new_entry.data_rdy = 1'b0;
    end
`ifdef MEM_SCHED_LOAD_BYPASS_EN
    new_entry.ea = calc_ea(alloc_base_val, alloc_offset, alloc_imm[ZP_WRAP_BIT]);
`endif
  end

  always_comb begin
    blocked  = '0;
    eligible = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (store_pend[j] && age[j] < age[i]) begin
`ifdef MEM_SCHED_LOAD_BYPASS_EN
          if (entries[i].opcode[STORE_BIT] || entries[j].ea == entries[i].ea) blocked[i] = 1'b1;
`else
          blocked[i] = 1'b1;
`endif
        end
      end
      eligible[i] = entries[i].valid && !entries[i].issued && entries[i].data_rdy && !blocked[i];
    end
  end

  // Retire the unbroken run of issued entries starting at head.
  always_comb begin
    retire_mask = '0;
    retire_cnt  = '0;
    ret_idx     = '0;
    ret_run     = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      ret_idx = head + PTR_W'(k);
      if (ret_run && entries[ret_idx].valid && entries[ret_idx].issued) begin
        retire_mask[ret_idx] = 1'b1;
        retire_cnt           = retire_cnt + (PTR_W+1)'(1);
      end else begin
        ret_run = 1'b0;
      end
    end
  end

  mem_sched_age_select #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_age_select (
    .eligible (eligible),
    .head     (head),
    .sel_idx  (sel_idx),
    .found    (found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      head               <= '0;
      tail               <= '0;
      occupancy          <= '0;
      iss_valid          <= 1'b0;
      iss_opcode         <= '0;
      iss_base_val       <= '0;
      iss_offset         <= '0;
      iss_dest_reg       <= '0;
      iss_data           <= '0;
      iss_imm            <= '0;
      iss_dest_arch_regs <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
      iss_valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (retire_mask[i]) begin
          entries[i].valid  <= 1'b0;
          entries[i].issued <= 1'b0;
        end else if (wake[i]) begin
          entries[i].data     <= cdb_val;
          entries[i].data_rdy <= 1'b1;
        end
      end
      if (issue_go) begin
        entries[sel_idx].issued <= 1'b1;
        iss_valid               <= 1'b1;
        iss_opcode              <= entries[sel_idx].opcode;
        iss_base_val            <= entries[sel_idx].base_val;
        iss_offset              <= entries[sel_idx].offset;
        iss_dest_reg            <= entries[sel_idx].dest_reg;
        iss_data                <= entries[sel_idx].data;
        iss_imm                 <= entries[sel_idx].imm;
        iss_dest_arch_regs      <= entries[sel_idx].dest_arch_regs;
      end else if (iss_ready) begin
        iss_valid <= 1'b0;
      end
      if (alloc_fire) begin
        entries[tail] <= new_entry;
        tail          <= tail + PTR_W'(1);
      end
      head      <= head + retire_cnt[PTR_W-1:0];
      occupancy <= occupancy + (PTR_W+1)'(alloc_fire) - retire_cnt;
    end
  end

endmodule
`default_nettype wire
